// File: rtl/tile_paint_if.sv
// Bundle between the VGA timing/keyboard side and tile_paint_gen.
// scan_valid is a one-cycle strobe with no ready: the producer never stalls, and bytes the block cannot use are dropped.
interface tile_paint_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic [7:0]  scan_code;
  logic        scan_valid;
  logic [7:0]  color;
  logic [4:0]  cursor_col;
  logic [3:0]  cursor_row;
  logic [2:0]  pen;
  logic        busy;
  logic [1:0]  key_state;

  modport master (
    output hcount, vcount, scan_code, scan_valid,
    input  color, cursor_col, cursor_row, pen, busy, key_state
  );

  modport slave (
    input  hcount, vcount, scan_code, scan_valid,
    output color, cursor_col, cursor_row, pen, busy, key_state
  );
endinterface

// File: rtl/tile_paint_gen.sv
// Keyboard-driven tile painter feeding one-hot colour codes to the VGA stage.
// Optional macro CURSOR_BLINK_EN: cursor border blinks on a 64-frame cycle.
module tile_paint_gen #(
  parameter int TILE_SHIFT = 5,
  parameter int COLS       = 20,
  parameter int ROWS       = 15
) (
  input  logic        clk,
  input  logic        reset,
  tile_paint_if.slave bus
);
  localparam int N_TILES = COLS * ROWS;
  localparam int AW      = $clog2(N_TILES);

  typedef enum logic [1:0] {IDLE = 2'd0, BRK = 2'd1, CLR = 2'd2} key_state_t;

  key_state_t     state;
  logic [AW-1:0]  clr_idx;
  logic           paint_req;
  logic [AW-1:0]  paint_addr;
  logic [2:0]     paint_data;
  logic [4:0]     cur_col;
  logic [3:0]     cur_row;
  logic [2:0]     pen_r;
  logic           busy_r;
  logic [AW-1:0]  cursor_addr;

  logic [2:0]     tile_ram [0:N_TILES-1];

  assign cursor_addr = AW'(cur_row) * AW'(COLS) + AW'(cur_col);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CLR;
      clr_idx    <= '0;
      paint_req  <= 1'b0;
      paint_addr <= '0;
      paint_data <= 3'd0;
      cur_col    <= 5'd0;
      cur_row    <= 4'd0;
      pen_r      <= 3'd1;
      busy_r     <= 1'b1;
    end else begin
      paint_req <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.scan_valid) begin
            case (bus.scan_code)
              8'hF0: state <= BRK;
              8'hE0: ;
              8'h1D: if (cur_row != 4'd0) cur_row <= cur_row - 4'd1;
              8'h1B: if (cur_row != 4'(ROWS - 1)) cur_row <= cur_row + 4'd1;
              8'h1C: if (cur_col != 5'd0) cur_col <= cur_col - 5'd1;
              8'h23: if (cur_col != 5'(COLS - 1)) cur_col <= cur_col + 5'd1;
              8'h16: pen_r <= 3'd0;
              8'h1E: pen_r <= 3'd1;
              8'h26: pen_r <= 3'd2;
              8'h25: pen_r <= 3'd3;
              8'h2E: pen_r <= 3'd4;
              8'h36: pen_r <= 3'd5;
              8'h3D: pen_r <= 3'd6;
              8'h3E: pen_r <= 3'd7;
              8'h29: begin
                paint_req  <= 1'b1;
                paint_addr <= cursor_addr;
                paint_data <= pen_r;
              end
              8'h21: begin
                state   <= CLR;
                clr_idx <= '0;
                busy_r  <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        BRK: if (bus.scan_valid) state <= IDLE;
        CLR: begin
          // Every strobe is dropped here, including F0.
          if (clr_idx == AW'(N_TILES - 1)) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end else begin
            clr_idx <= clr_idx + AW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Single write port: the clear sweep owns it while running.
  always_ff @(posedge clk) begin
    if (state == CLR) tile_ram[clr_idx] <= 3'd0;
    else if (paint_req) tile_ram[paint_addr] <= paint_data;
  end

  logic [10:0]           htile_c, vtile_c;
  logic [TILE_SHIFT-1:0] lx_c, ly_c;
  logic                  visible_c, on_edge_c, in_cursor_c, border_c, blink_on;
  logic [AW-1:0]         rd_addr_c;

  assign htile_c     = bus.hcount >> TILE_SHIFT;
  assign vtile_c     = bus.vcount >> TILE_SHIFT;
  assign lx_c        = bus.hcount[TILE_SHIFT-1:0];
  assign ly_c        = bus.vcount[TILE_SHIFT-1:0];
  assign visible_c   = (bus.hcount < 11'(COLS << TILE_SHIFT)) && (bus.vcount < 11'(ROWS << TILE_SHIFT));
  assign rd_addr_c   = visible_c ? (AW'(vtile_c) * AW'(COLS) + AW'(htile_c)) : '0;
  assign in_cursor_c = (htile_c == 11'(cur_col)) && (vtile_c == 11'(cur_row));
  assign on_edge_c   = (lx_c == '0) || (lx_c == '1) || (ly_c == '0) || (ly_c == '1);
  assign border_c    = visible_c && in_cursor_c && on_edge_c && blink_on;

`ifdef CURSOR_BLINK_EN
  logic [5:0] frame_cnt;
  always_ff @(posedge clk) begin
    if (reset) frame_cnt <= 6'd0;
    else if (bus.hcount == 11'd0 && bus.vcount == 11'd0) frame_cnt <= frame_cnt + 6'd1;
  end
  assign blink_on = ~frame_cnt[5];
`else
  assign blink_on = 1'b1;
`endif

  logic       vis_q, border_q;
  logic [2:0] tile_q;
  logic [7:0] color_r;

  // Synchronous read sees the pre-write value on a same-cycle collision.
  always_ff @(posedge clk) begin
    tile_q <= tile_ram[rd_addr_c];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vis_q    <= 1'b0;
      border_q <= 1'b0;
      color_r  <= 8'b0000_0001;
    end else begin
      vis_q    <= visible_c;
      border_q <= border_c;
      if (!vis_q)        color_r <= 8'b0000_0001;
      else if (border_q) color_r <= (tile_q == 3'd7) ? 8'b0000_0001 : 8'b1000_0000;
      else               color_r <= 8'b0000_0001 << tile_q;
    end
  end

  assign bus.color      = color_r;
  assign bus.cursor_col = cur_col;
  assign bus.cursor_row = cur_row;
  assign bus.pen        = pen_r;
  assign bus.busy       = busy_r;
  assign bus.key_state  = state;
endmodule

// File: tb/tb_tile_paint_gen.sv
// Directed self-checking bench for tile_paint_gen: reset/clear timing, cursor, pen, paint, break codes.
module tb_tile_paint_gen;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  tile_paint_if bus ();

  tile_paint_gen dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send_key(input logic [7:0] code);
    bus.scan_code  = code;
    bus.scan_valid = 1'b1;
    @(negedge clk);
    bus.scan_valid = 1'b0;
  endtask

  task automatic send_keys(input logic [7:0] code, input int n);
    for (int i = 0; i < n; i++) send_key(code);
  endtask

  task automatic set_pix(input int h, input int v);
    bus.hcount = 11'(h);
    bus.vcount = 11'(v);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    int cnt;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.color !== 8'h01) begin failures++; $display("FAIL reset_color got=%h exp=01", bus.color); end
    checks++; if (bus.cursor_col !== 5'd0) begin failures++; $display("FAIL reset_col got=%0d exp=0", bus.cursor_col); end
    checks++; if (bus.cursor_row !== 4'd0) begin failures++; $display("FAIL reset_row got=%0d exp=0", bus.cursor_row); end
    checks++; if (bus.pen !== 3'd1) begin failures++; $display("FAIL reset_pen got=%0d exp=1", bus.pen); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", bus.busy); end
    reset = 1'b0;
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    checks++; if (cnt != 300) begin failures++; $display("FAIL init_clear_cycles got=%0d exp=300", cnt); end
    checks++; if (bus.key_state !== 2'd0) begin failures++; $display("FAIL init_idle_state got=%0d exp=0", bus.key_state); end
    set_pix(100, 100);
    checks++; if (bus.color !== 8'h01) begin failures++; $display("FAIL pix_100_100 got=%h exp=01", bus.color); end
    set_pix(700, 100);
    checks++; if (bus.color !== 8'h01) begin failures++; $display("FAIL pix_not_visible got=%h exp=01", bus.color); end
  endtask

  task automatic test_move;
    send_keys(8'h23, 3);
    send_keys(8'h1B, 2);
    checks++; if (bus.cursor_col !== 5'd3) begin failures++; $display("FAIL move_col got=%0d exp=3", bus.cursor_col); end
    checks++; if (bus.cursor_row !== 4'd2) begin failures++; $display("FAIL move_row got=%0d exp=2", bus.cursor_row); end
    send_keys(8'h1C, 5);
    checks++; if (bus.cursor_col !== 5'd0) begin failures++; $display("FAIL sat_col_low got=%0d exp=0", bus.cursor_col); end
    send_keys(8'h1B, 20);
    checks++; if (bus.cursor_row !== 4'd14) begin failures++; $display("FAIL sat_row_high got=%0d exp=14", bus.cursor_row); end
    send_keys(8'h23, 25);
    checks++; if (bus.cursor_col !== 5'd19) begin failures++; $display("FAIL sat_col_high got=%0d exp=19", bus.cursor_col); end
    send_keys(8'h1C, 19);
    checks++; if (bus.cursor_col !== 5'd0) begin failures++; $display("FAIL col_back got=%0d exp=0", bus.cursor_col); end
  endtask

  task automatic test_pen;
    logic [7:0] codes [8];
    codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E};
    for (int i = 7; i >= 0; i--) begin
      send_key(codes[i]);
      checks++; if (bus.pen !== 3'(i)) begin failures++; $display("FAIL pen_key_%0d got=%0d exp=%0d", i, bus.pen, i); end
    end
  endtask

  task automatic test_paint;
    send_keys(8'h23, 3);
    send_keys(8'h1D, 12);
    checks++; if (bus.cursor_row !== 4'd2 || bus.cursor_col !== 5'd3) begin
      failures++; $display("FAIL paint_cursor got=(%0d,%0d) exp=(3,2)", bus.cursor_col, bus.cursor_row);
    end
    send_key(8'h26);
    checks++; if (bus.pen !== 3'd2) begin failures++; $display("FAIL paint_pen got=%0d exp=2", bus.pen); end
    send_key(8'h29);
    @(negedge clk);
    set_pix(110, 75);
    checks++; if (bus.color !== 8'h04) begin failures++; $display("FAIL paint_interior got=%h exp=04", bus.color); end
    set_pix(96, 80);
    checks++; if (bus.color !== 8'h80) begin failures++; $display("FAIL paint_border_left got=%h exp=80", bus.color); end
    set_pix(127, 95);
    checks++; if (bus.color !== 8'h80) begin failures++; $display("FAIL paint_border_right got=%h exp=80", bus.color); end
    set_pix(140, 75);
    checks++; if (bus.color !== 8'h01) begin failures++; $display("FAIL neighbour_tile got=%h exp=01", bus.color); end
  endtask

  task automatic test_break;
    send_key(8'hF0);
    checks++; if (bus.key_state !== 2'd1) begin failures++; $display("FAIL brk_state got=%0d exp=1", bus.key_state); end
    send_key(8'h23);
    checks++; if (bus.cursor_col !== 5'd3) begin failures++; $display("FAIL brk_discard got=%0d exp=3", bus.cursor_col); end
    send_key(8'hE0);
    send_key(8'h23);
    checks++; if (bus.cursor_col !== 5'd4) begin failures++; $display("FAIL e0_then_d got=%0d exp=4", bus.cursor_col); end
    send_key(8'h5A);
    checks++; if (bus.cursor_col !== 5'd4 || bus.pen !== 3'd2 || bus.key_state !== 2'd0) begin
      failures++; $display("FAIL unknown_code got=col%0d pen%0d st%0d exp=col4 pen2 st0", bus.cursor_col, bus.pen, bus.key_state);
    end
  endtask

  task automatic test_clear;
    int cnt;
    send_keys(8'h1C, 4);
    send_keys(8'h1D, 3);
    checks++; if (bus.cursor_row !== 4'd0 || bus.cursor_col !== 5'd0) begin
      failures++; $display("FAIL clr_cursor got=(%0d,%0d) exp=(0,0)", bus.cursor_col, bus.cursor_row);
    end
    send_key(8'h3E);
    send_key(8'h29);
    @(negedge clk);
    set_pix(16, 16);
    checks++; if (bus.color !== 8'h80) begin failures++; $display("FAIL pen7_interior got=%h exp=80", bus.color); end
    set_pix(0, 16);
    checks++; if (bus.color !== 8'h01) begin failures++; $display("FAIL pen7_border got=%h exp=01", bus.color); end
    send_key(8'h21);
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 1000) begin
      bus.scan_valid = (cnt == 10) || (cnt == 20);
      bus.scan_code  = (cnt == 20) ? 8'hF0 : 8'h23;
      @(negedge clk);
      cnt++;
    end
    bus.scan_valid = 1'b0;
    checks++; if (cnt != 300) begin failures++; $display("FAIL clear_cycles got=%0d exp=300", cnt); end
    checks++; if (bus.cursor_col !== 5'd0) begin failures++; $display("FAIL clear_drop_key got=%0d exp=0", bus.cursor_col); end
    checks++; if (bus.key_state !== 2'd0) begin failures++; $display("FAIL clear_drop_f0 got=%0d exp=0", bus.key_state); end
    set_pix(16, 16);
    checks++; if (bus.color !== 8'h01) begin failures++; $display("FAIL after_clear got=%h exp=01", bus.color); end
    send_key(8'h23);
    checks++; if (bus.cursor_col !== 5'd1) begin failures++; $display("FAIL key_after_clear got=%0d exp=1", bus.cursor_col); end
  endtask

  task automatic test_reset_mid_clear;
    int cnt;
    bus.hcount = 11'd700;
    send_key(8'h1B);
    send_key(8'h16);
    send_key(8'h21);
    repeat (50) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.color !== 8'h01) begin failures++; $display("FAIL mid_color got=%h exp=01", bus.color); end
    checks++; if (bus.cursor_col !== 5'd0 || bus.cursor_row !== 4'd0) begin
      failures++; $display("FAIL mid_cursor got=(%0d,%0d) exp=(0,0)", bus.cursor_col, bus.cursor_row);
    end
    checks++; if (bus.pen !== 3'd1) begin failures++; $display("FAIL mid_pen got=%0d exp=1", bus.pen); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", bus.busy); end
    reset = 1'b0;
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    checks++; if (cnt != 300) begin failures++; $display("FAIL mid_clear_cycles got=%0d exp=300", cnt); end
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    reset          = 1'b1;
    bus.hcount     = 11'd700;
    bus.vcount     = 11'd500;
    bus.scan_code  = 8'h00;
    bus.scan_valid = 1'b0;
    @(negedge clk);
    test_reset();
    test_move();
    test_pen();
    test_paint();
    test_break();
    test_clear();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
